// File: rtl/game_control.sv
// 4K falling-note game core: scrolls chart rows down four lane bitmaps, judges key presses, keeps score/combo.
// Optional build macro GAME_CONTROL_AUTOPLAY_EN: every note reaching bit 0 on a tick counts as a perfect hit.
module game_control #(
  parameter logic [31:0] TICK_DIV    = 32'd200000,
  parameter int          JUDGE_WIN   = 32,
  parameter int          PERFECT_WIN = 8,
  parameter logic [31:0] GOOD_PTS    = 32'd100,
  parameter logic [31:0] PERFECT_PTS = 32'd300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key0,
  input  logic         key1,
  input  logic         key2,
  input  logic         key3,
  input  logic [1:0]   sw,
  output logic [31:0]  score,
  output logic [15:0]  combo,
  output logic [479:0] track0,
  output logic [479:0] track1,
  output logic [479:0] track2,
  output logic [479:0] track3,
  output logic [10:0]  readAddr,
  output logic [31:0]  timecnt,
  output logic [15:0]  readcnt
);

  logic [479:0] trk      [4];
  logic [479:0] trk_next [4];
  logic [31:0]  divider;
  logic [31:0]  period;
  logic         paused;
  logic         tick;
  logic [3:0]   keys;
  logic [3:0]   key_prev;
  logic [3:0]   press;
  logic [3:0]   hit_key;
  logic [3:0]   near;
  logic [3:0]   auto_hit;
  logic [3:0]   hit;
  logic [3:0]   perfect;
  logic [3:0]   miss;
  logic [3:0]   mask;
  logic [1:0]   lane_a;
  logic [1:0]   lane_b;
  logic [2:0]   n_hit;
  logic [2:0]   n_perf;
  logic [31:0]  pts;
  logic [16:0]  combo_sum;
  logic [32:0]  score_sum;

  assign track0 = trk[0];
  assign track1 = trk[1];
  assign track2 = trk[2];
  assign track3 = trk[3];

  always_comb begin
    period = TICK_DIV;
    case (sw)
      2'b01:   period = TICK_DIV >> 1;
      2'b10:   period = TICK_DIV >> 2;
      default: period = TICK_DIV;
    endcase
  end

  // ">=" lets a speed-up mid-count fire on the very next cycle
  assign paused = (sw == 2'b11);
  assign tick   = !paused && (divider >= period - 32'd1);

  always_comb begin
    lane_a = readAddr[5:4];
    lane_b = lane_a + 2'd2;
    mask   = '0;
    if (readAddr[3:0] == 4'd0) begin
      mask[lane_a] = 1'b1;
      if (readAddr[6]) mask[lane_b] = 1'b1;
    end
  end

  assign keys  = {key3, key2, key1, key0};
  assign press = keys & ~key_prev;

  always_comb begin
    hit_key  = '0;
    near     = '0;
    auto_hit = '0;
    hit      = '0;
    perfect  = '0;
    miss     = '0;
    n_hit    = '0;
    n_perf   = '0;
    for (int n = 0; n < 4; n++) begin
      hit_key[n] = press[n] && (|trk[n][JUDGE_WIN-1:0]);
      near[n]    = |trk[n][PERFECT_WIN-1:0];
`ifdef GAME_CONTROL_AUTOPLAY_EN
      auto_hit[n] = tick && trk[n][0];
`else
      auto_hit[n] = 1'b0;
`endif
      hit[n]     = hit_key[n] | auto_hit[n];
      perfect[n] = auto_hit[n] | (hit_key[n] & near[n]);
      miss[n]    = tick && trk[n][0] && !hit[n];
      trk_next[n] = tick ? {mask[n], trk[n][479:1]} : trk[n];
      // the hit clears the window after the shift, so the judged notes never survive a tick
      if (hit_key[n]) trk_next[n][JUDGE_WIN-1:0] = '0;
      n_hit  = n_hit + {2'b00, hit[n]};
      n_perf = n_perf + {2'b00, perfect[n]};
    end
  end

  always_comb begin
    pts       = {29'd0, n_perf} * PERFECT_PTS + {29'd0, n_hit - n_perf} * GOOD_PTS;
    combo_sum = ((|miss) ? 17'd0 : {1'b0, combo}) + {14'd0, n_hit};
    score_sum = {1'b0, score} + {1'b0, pts};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) trk[n] <= '0;
      key_prev <= '0;
      divider  <= '0;
      score    <= '0;
      combo    <= '0;
      readAddr <= '0;
      timecnt  <= '0;
      readcnt  <= '0;
    end else begin
      key_prev <= keys;
      for (int n = 0; n < 4; n++) trk[n] <= trk_next[n];
      combo <= combo_sum[16] ? 16'hFFFF : combo_sum[15:0];
      score <= score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];
      if (!paused) begin
        timecnt <= timecnt + 32'd1;
        if (tick) divider <= '0;
        else      divider <= divider + 32'd1;
      end
      if (tick) begin
        readAddr <= readAddr + 11'd1;
        readcnt  <= readcnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: directed vector table plus a cycle model feeding a scoreboard queue.
module tb_game_control;
  localparam logic [31:0] TD = 32'd4;
  localparam int JW = 32;
  localparam int PW = 8;
`ifdef GAME_CONTROL_AUTOPLAY_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic key0, key1, key2, key3;
  logic [1:0] sw;
  logic [31:0] score;
  logic [15:0] combo;
  logic [479:0] track0, track1, track2, track3;
  logic [10:0] readAddr;
  logic [31:0] timecnt;
  logic [15:0] readcnt;

  game_control #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .sw(sw), .score(score), .combo(combo),
    .track0(track0), .track1(track1), .track2(track2), .track3(track3),
    .readAddr(readAddr), .timecnt(timecnt), .readcnt(readcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  score;
    logic [15:0]  combo;
    logic [10:0]  ra;
    logic [31:0]  tc;
    logic [15:0]  rc;
    logic [479:0] t0, t1, t2, t3;
  } exp_t;

  typedef struct {
    logic        r;
    logic [3:0]  k;
    logic [1:0]  s;
    logic [31:0] e_score;
    logic [15:0] e_combo;
    logic [10:0] e_ra;
    logic [31:0] e_tc;
    logic [15:0] e_rc;
    logic        e_top0;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[6];
  int n_checks = 0;
  int n_errors = 0;

  logic [479:0] mt [4];
  logic [31:0]  ms, mtc, mdiv;
  logic [15:0]  mc, mrc;
  logic [10:0]  mra;
  logic [3:0]   mprev;
  int           auto_hits;

  task automatic chk(input string name, input logic [479:0] act, input logic [479:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] chart(input logic [10:0] r);
    if (r[3:0] != 4'd0) return 4'b0000;
    case (r[6:4])
      3'd0:    return 4'b0001;
      3'd1:    return 4'b0010;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b1000;
      3'd4:    return 4'b0101;
      3'd5:    return 4'b1010;
      3'd6:    return 4'b0101;
      default: return 4'b1010;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [3:0] k, input logic [1:0] s);
    int p, nh, np, c;
    bit tk, miss_any, hk, au;
    logic [3:0] m;
    logic [479:0] old;
    longint sc;
    exp_t e;
    if (r) begin
      for (int n = 0; n < 4; n++) mt[n] = '0;
      ms = 0; mc = 0; mtc = 0; mdiv = 0; mra = 0; mrc = 0; mprev = 0; auto_hits = 0;
    end else begin
      p  = (s == 2'b00) ? int'(TD) : (s == 2'b01) ? int'(TD / 2) : int'(TD / 4);
      tk = (s != 2'b11) && (int'(mdiv) >= p - 1);
      m  = chart(mra);
      nh = 0; np = 0; miss_any = 0;
      for (int n = 0; n < 4; n++) begin
        old = mt[n];
        hk  = k[n] && !mprev[n] && (old[JW-1:0] != '0);
        au  = AUTO && tk && old[0];
        if (hk || au) begin
          nh++;
          if (au || old[PW-1:0] != '0) np++;
        end
        if (au) auto_hits++;
        if (tk && old[0] && !hk && !au) miss_any = 1;
        if (tk) mt[n] = {m[n], old[479:1]};
        if (hk) mt[n][JW-1:0] = '0;
      end
      c = (miss_any ? 0 : int'(mc)) + nh;
      if (c > 65535) c = 65535;
      mc = 16'(c);
      sc = longint'(ms) + longint'(np * 300) + longint'((nh - np) * 100);
      if (sc > 64'd4294967295) sc = 64'd4294967295;
      ms = sc[31:0];
      mprev = k;
      if (s != 2'b11) begin
        mtc = mtc + 1;
        if (tk) mdiv = 0;
        else    mdiv = mdiv + 1;
      end
      if (tk) begin
        mra = mra + 1;
        mrc = mrc + 1;
      end
    end
    e.score = ms; e.combo = mc; e.ra = mra; e.tc = mtc; e.rc = mrc;
    e.t0 = mt[0]; e.t1 = mt[1]; e.t2 = mt[2]; e.t3 = mt[3];
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sbq.size() == 0) begin
      n_errors++;
      $display("FAIL sb_empty: got no entry expected one");
      return;
    end
    e = sbq.pop_front();
    chk("sb_score", score, e.score);
    chk("sb_combo", combo, e.combo);
    chk("sb_readAddr", readAddr, e.ra);
    chk("sb_timecnt", timecnt, e.tc);
    chk("sb_readcnt", readcnt, e.rc);
    chk("sb_track0", track0, e.t0);
    chk("sb_track1", track1, e.t1);
    chk("sb_track2", track2, e.t2);
    chk("sb_track3", track3, e.t3);
  endtask

  task automatic cyc(input logic r, input logic [3:0] k, input logic [1:0] s);
    rst = r;
    {key3, key2, key1, key0} = k;
    sw = s;
    model_step(r, k, s);
    @(posedge clk);
    #1;
    sb_check();
  endtask

  initial begin
    int i, rnd;
    logic [31:0] ps, st;
    logic [15:0] pc, src;
    logic [10:0] sa;
    logic [479:0] s0;

    rst = 1'b1; key0 = 1'b1; key1 = 1'b1; key2 = 1'b1; key3 = 1'b1; sw = 2'b00;
    for (int n = 0; n < 4; n++) mt[n] = '0;
    ms = 0; mc = 0; mtc = 0; mdiv = 0; mra = 0; mrc = 0; mprev = 0; auto_hits = 0;

    tbl[0] = '{1'b1, 4'hF, 2'b00, 32'd0, 16'd0, 11'd0, 32'd0, 16'd0, 1'b0};
    tbl[1] = '{1'b1, 4'hF, 2'b00, 32'd0, 16'd0, 11'd0, 32'd0, 16'd0, 1'b0};
    tbl[2] = '{1'b0, 4'h0, 2'b00, 32'd0, 16'd0, 11'd0, 32'd1, 16'd0, 1'b0};
    tbl[3] = '{1'b0, 4'h0, 2'b00, 32'd0, 16'd0, 11'd0, 32'd2, 16'd0, 1'b0};
    tbl[4] = '{1'b0, 4'h0, 2'b00, 32'd0, 16'd0, 11'd0, 32'd3, 16'd0, 1'b0};
    tbl[5] = '{1'b0, 4'h0, 2'b00, 32'd0, 16'd0, 11'd1, 32'd4, 16'd1, 1'b1};

    for (int v = 0; v < 6; v++) begin
      cyc(tbl[v].r, tbl[v].k, tbl[v].s);
      chk($sformatf("vec%0d_score", v), score, tbl[v].e_score);
      chk($sformatf("vec%0d_combo", v), combo, tbl[v].e_combo);
      chk($sformatf("vec%0d_readAddr", v), readAddr, tbl[v].e_ra);
      chk($sformatf("vec%0d_timecnt", v), timecnt, tbl[v].e_tc);
      chk($sformatf("vec%0d_readcnt", v), readcnt, tbl[v].e_rc);
      chk($sformatf("vec%0d_track0_top", v), track0[479], tbl[v].e_top0);
    end

    // row 64 is a two-lane note (lanes 0 and 2)
    i = 0;
    while (mra != 11'd65 && i < 2000) begin cyc(1'b0, 4'h0, 2'b00); i++; end
    chk("to_row64", mra == 11'd65, 1'b1);
    chk("row64_t0_top", track0[479], 1'b1);
    chk("row64_t1_top", track1[479], 1'b0);
    chk("row64_t2_top", track2[479], 1'b1);
    chk("row64_t3_top", track3[479], 1'b0);

    i = 0;
    while (mrc != 16'd480 && i < 2000) begin cyc(1'b0, 4'h0, 2'b00); i++; end
    chk("to_tick480", mrc == 16'd480, 1'b1);
    chk("row0_at_line", track0[0], 1'b1);
    i = 0;
    while (mrc != 16'd481 && i < 10) begin cyc(1'b0, 4'h0, 2'b00); i++; end
    chk("row0_gone", track0[0], 1'b0);
    chk("miss_combo", combo, 16'd0);
    chk("miss_score", score, 32'd0);

    // perfect hit on lane 0, then hold the key
    i = 0;
    while (mt[0][3] != 1'b1 && i < 400) begin cyc(1'b0, 4'h0, 2'b00); i++; end
    chk("to_perfect", mt[0][3], 1'b1);
    cyc(1'b0, 4'b0001, 2'b00);
    chk("perfect_score", score, 32'd300);
    chk("perfect_combo", combo, 16'd1);
    chk("perfect_win_clear", track0[31:0], 32'd0);
    for (int h = 0; h < 8; h++) cyc(1'b0, 4'b0001, 2'b00);
    chk("hold_score", score, 32'd300);
    chk("hold_combo", combo, 16'd1);
    cyc(1'b0, 4'h0, 2'b00);

    // good hit on lane 1 at bit 20, then a press on the now-empty window
    i = 0;
    while (!(mt[1][20] == 1'b1 && mt[1][PW-1:0] == '0) && i < 400) begin cyc(1'b0, 4'h0, 2'b00); i++; end
    chk("to_good", mt[1][20], 1'b1);
    ps = ms; pc = mc;
    cyc(1'b0, 4'b0010, 2'b00);
    chk("good_score", score, ps + 32'd100);
    chk("good_combo", combo, pc + 16'd1);
    cyc(1'b0, 4'h0, 2'b00);
    cyc(1'b0, 4'b0010, 2'b00);
    chk("empty_score", score, ps + 32'd100);
    chk("empty_combo", combo, pc + 16'd1);
    cyc(1'b0, 4'h0, 2'b00);

    // lane 0 misses on the same tick that lane 2 is hit
    i = 0;
    while (!(mt[0][0] == 1'b1 && mdiv == 32'd3 && mt[2][JW-1:0] != '0) && i < 400) begin
      cyc(1'b0, 4'h0, 2'b00); i++;
    end
    chk("to_simul", mt[0][0] == 1'b1 && mdiv == 32'd3, 1'b1);
    ps = ms;
    cyc(1'b0, 4'b0100, 2'b00);
    chk("simul_combo", combo, 16'd1);
    chk("simul_score", score, ps + 32'd300);
    chk("simul_t2_clear", track2[31:0], 32'd0);
    cyc(1'b0, 4'h0, 2'b00);

    sa = mra;
    for (int h = 0; h < 5; h++) cyc(1'b0, 4'h0, 2'b10);
    chk("div4_readAddr", readAddr, sa + 11'd5);
    src = mrc;
    for (int h = 0; h < 8; h++) cyc(1'b0, 4'h0, 2'b01);
    chk("div2_readcnt", readcnt, src + 16'd4);

    st = mtc; sa = mra; s0 = mt[0];
    for (int h = 0; h < 10; h++) cyc(1'b0, (h == 3) ? 4'b1000 : 4'h0, 2'b11);
    chk("pause_timecnt", timecnt, st);
    chk("pause_readAddr", readAddr, sa);
    chk("pause_track0", track0, s0);

    for (int h = 0; h < 400; h++) begin
      rnd = int'($urandom_range(0, 9));
      cyc(1'b0, 4'($urandom_range(0, 15)),
          (rnd < 4) ? 2'b00 : (rnd < 6) ? 2'b01 : (rnd < 8) ? 2'b10 : 2'b11);
    end

    // fresh game: 1000 ticks without keys; rows 0..519 carry 49 notes that get judged
    cyc(1'b1, 4'h0, 2'b00);
    cyc(1'b1, 4'h0, 2'b00);
    i = 0;
    while (mrc != 16'd1000 && i < 4100) begin cyc(1'b0, 4'h0, 2'b00); i++; end
    chk("to_tick1000", mrc == 16'd1000, 1'b1);
    chk("auto_combo", combo, AUTO ? 16'd49 : 16'd0);
    chk("auto_score", score, AUTO ? 32'd14700 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
- Core controller of the 4-key falling-note rhythm game (4K mania).
- Reads note rows from an internal 2048-row chart and scrolls them down four 480-row lane bitmaps. The display layer renders these bitmaps.
- Judges key presses against a window at the bottom of each lane.
- Maintains score, combo, game time and chart read position.

Parameters:
- TICK_DIV, 32'd200000, clock cycles per scroll tick at normal speed (must be ≥4 and divisible by 4).
- JUDGE_WIN, 32, rows [JUDGE_WIN-1:0] of each lane form the hit window.
- PERFECT_WIN, 8, rows [PERFECT_WIN-1:0] form the perfect sub-window (PERFECT_WIN ≤ JUDGE_WIN).
- GOOD_PTS, 100, score added per good hit.
- PERFECT_PTS, 300, score added per perfect hit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key0..key3  in  1 each  lane buttons, level, high = pressed.
- sw  in  2  speed select: 00 = TICK_DIV, 01 = TICK_DIV/2, 10 = TICK_DIV/4, 11 = paused.
- score  out  32  accumulated score.
- combo  out  16  consecutive hits.
- track0..track3  out  480 each  lane bitmaps; bit 479 = top row, bit 0 = judgement line.
- readAddr  out  11  chart row fetched at the next tick.
- timecnt  out  32  running cycles (game time).
- readcnt  out  16  total chart rows fetched.

Behaviour:
- Reset (rst=1 at an edge):
  - score, combo, track0-3, readAddr, timecnt, readcnt, divider and key history all clear to 0.
  - Reset mid-game discards all state the same way.
- Timing:
  - When sw≠11, timecnt increments by 1 each cycle and wraps at 2^32.
  - The divider counts 0..P-1, where P is the sw-selected period.
  - A scroll tick occurs in the cycle where divider==P-1; the divider then returns to 0.
  - If sw changes while divider ≥ new P-1, the tick fires at the next cycle and the divider returns to 0.
  - When sw=11, timecnt, divider, tracks and readAddr all hold. Judging still works on keys.
- Chart ROM: internal and combinational, indexed by readAddr. Row r yields lane mask m[3:0]:
  - If r[3:0]≠0, m=0.
  - Otherwise m has bit r[5:4] set, plus bit (r[5:4]+2) mod 4 when r[6]=1.
- Scroll tick:
  - Each lane: trackN <= {m[N], trackN[479:1]}.
  - readAddr increments and wraps 2047→0.
  - readcnt increments and wraps at 2^16.
- Miss:
  - On a tick, any lane whose bit 0 is 1 and is not hit in that cycle is a miss.
  - A miss sets combo to 0; score is unchanged.
- Press detection:
  - Rising edge press_N = keyN & ~keyN_prev; keyN_prev is registered every cycle.
  - A held key yields one press only.
- Hit evaluation on press_N, using the pre-shift bitmap:
  - If trackN[JUDGE_WIN-1:0] is zero, no effect (no penalty).
  - Else the hit is perfect if any bit in [PERFECT_WIN-1:0] is set, otherwise good.
  - On a hit, bits [JUDGE_WIN-1:0] of trackN are cleared. If a tick occurs in the same cycle, the clearing applies to the shifted result, so those notes vanish.
- Same-cycle combination:
  - Misses are applied first, then hits.
  - combo_next = (any miss ? 0 : combo) + number_of_hits, saturating at 65535.
  - score_next = score + sum of points for all hits, saturating at 2^32-1.
- All outputs are registered.
- Latency: press at edge k updates score/combo/tracks at edge k+1.

Optional Feature:
- Macro GAME_CONTROL_AUTOPLAY_EN.
- Defined:
  - On every tick, each lane with bit 0 set is treated as a perfect hit (+PERFECT_PTS, combo+1) and never as a miss.
  - Key presses are still judged normally.
- Undefined: judging comes from keys only, as above.

Test Plan:
- Reset: assert rst 2 cycles with keys high → all outputs 0. Release with sw=00, TICK_DIV=4 → first tick on the 4th edge: track0[479]=1, readAddr=1, readcnt=1, timecnt=4.
- Scroll: 480 ticks after the first tick with no keys → lane-0 note leaves bit 0 as a miss: combo=0, score=0. Row 64 gives a two-lane note in track0 and track2.
- Perfect hit: when track0 bit 3 is set, raise key0 → next edge score=300, combo=1, track0[31:0]=0. Holding key0 gives no further scoring.
- Good hit: press key1 when its note is at bit 20 → score +100, combo +1. Pressing with an empty window leaves score and combo unchanged.
- Simultaneous: press key2 on the same cycle lane0 misses at bit 0 → combo=1, score += hit points.
- Pause and autoplay: sw=11 freezes timecnt, readAddr and tracks. With GAME_CONTROL_AUTOPLAY_EN defined and no keys, after 1000 ticks combo equals the number of notes that reached bit 0, and score = 300×combo.
